// File: rtl/sap_program_loader.sv
// sap_program_loader
//   Copies a stream of program bytes into the SAP-1 RAM by driving the W bus
//   and strobing the MAR and RAM latches. Each byte is written as an address
//   phase followed by a data phase. Each phase holds bus and strobe for
//   SETUP_CYCLES cycles, pulses the one-shot RAM clock for one cycle, and then
//   holds for one more cycle.
//
//   Parameters
//     DEPTH          words written per load (2..16)
//     SETUP_CYCLES   cycles bus/strobe are held before each RAM clock pulse (1..15)
//
//   Ports
//     clk_i            system clock, rising edge
//     rst_n_i          synchronous active-low reset
//     start_i          begin a load (sampled only in IDLE)
//     in_valid_i       source byte valid
//     in_data_i        source program byte
//     in_ready_o       byte accepted this cycle when in_valid_i is high
//     bus_out_o        value driven onto the W bus (0 when not driving)
//     bus_oe_o         loader owns the W bus
//     maddr_latch_o    MAR latch strobe
//     ram_latch_o      RAM write strobe
//     ram_clk_pulse_o  one-cycle pulse ORed into the one-shot clock
//     hold_cpu_o       hold CPU in reset during a load
//     busy_o           load in progress
//     done_o           one-cycle pulse after the final word
//     cur_addr_o       address currently being written
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE      | no load; waiting for start
//   WAIT_BYTE | in_ready high; waiting for a source byte
//   A_SETUP   | address on bus, MAR latch high, setup countdown
//   A_PULSE   | address phase RAM clock pulse
//   A_HOLD    | address held one cycle after the pulse
//   D_SETUP   | byte on bus, RAM latch high, setup countdown
//   D_PULSE   | data phase RAM clock pulse
//   D_HOLD    | byte held; advance address or finish
//   DONE      | done pulse, back to IDLE

module sap_program_loader #(
    parameter int DEPTH        = 16,
    parameter int SETUP_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic [7:0] bus_out_o,
    output logic       bus_oe_o,
    output logic       maddr_latch_o,
    output logic       ram_latch_o,
    output logic       ram_clk_pulse_o,
    output logic       hold_cpu_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] cur_addr_o
);

    localparam logic [3:0] LAST_ADDR  = 4'(DEPTH - 1);
    // Down-counter reload: terminal count 0 gives SETUP_CYCLES cycles in setup.
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_BYTE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic [3:0] addr_q, addr_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            byte_q  <= 8'd0;
            addr_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        byte_d          = byte_q;
        addr_d          = addr_q;
        in_ready_o      = 1'b0;
        bus_out_o       = 8'h00;
        bus_oe_o        = 1'b0;
        maddr_latch_o   = 1'b0;
        ram_latch_o     = 1'b0;
        ram_clk_pulse_o = 1'b0;
        done_o          = 1'b0;
        busy_o          = (state_q != IDLE);
        hold_cpu_o      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WAIT_BYTE;
                    addr_d  = 4'd0;
                end
            end
            WAIT_BYTE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    byte_d  = in_data_i;
                    cnt_d   = SETUP_LOAD;
                    state_d = A_SETUP;
                end
            end
            A_SETUP: begin
                bus_oe_o      = 1'b1;
                bus_out_o     = {4'h0, addr_q};
                maddr_latch_o = 1'b1;
                if (cnt_q == 4'd0) state_d = A_PULSE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            A_PULSE: begin
                bus_oe_o        = 1'b1;
                bus_out_o       = {4'h0, addr_q};
                maddr_latch_o   = 1'b1;
                ram_clk_pulse_o = 1'b1;
                state_d         = A_HOLD;
            end
            A_HOLD: begin
                bus_oe_o  = 1'b1;
                bus_out_o = {4'h0, addr_q};
                cnt_d     = SETUP_LOAD;
                state_d   = D_SETUP;
            end
            D_SETUP: begin
                bus_oe_o    = 1'b1;
                bus_out_o   = byte_q;
                ram_latch_o = 1'b1;
                if (cnt_q == 4'd0) state_d = D_PULSE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            D_PULSE: begin
                bus_oe_o        = 1'b1;
                bus_out_o       = byte_q;
                ram_latch_o     = 1'b1;
                ram_clk_pulse_o = 1'b1;
                state_d         = D_HOLD;
            end
            D_HOLD: begin
                bus_oe_o  = 1'b1;
                bus_out_o = byte_q;
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 4'd1;
                    state_d = WAIT_BYTE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_addr_o = addr_q;

endmodule
